// File: rtl/osc_tick_ctrl_pkg.sv
// osc_pkg: shared types, default parameters and a width helper for the
// PT2262/PT2272 oscillator tick controller.
package osc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } osc_state_t;

    localparam int OSC_DIV_W         = 16;
    localparam int OSC_DEFAULT_DIV   = 100;
    localparam int OSC_ALPHA_PER_BIT = 32;

    // Width able to hold the modulus value itself (not just modulus-1),
    // so a counter can be handed its modulus as a plain input.
    function automatic int cnt_width(input int m);
        int w;
        w = $clog2(m + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/osc_tick_ctrl_if.sv
// osc_if: control, configuration and tick bundle of the oscillator tick
// controller. Optional clk_out member exists only with OSC_TICK_CLKOUT_EN.
interface osc_if #(
    parameter int DIV_W = 16
);
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             running;
    logic             alpha_tick;
    logic             bit_tick;
    logic             done;
`ifdef OSC_TICK_CLKOUT_EN
    logic             clk_out;
`endif

    modport master (
`ifdef OSC_TICK_CLKOUT_EN
        input  clk_out,
`endif
        output start, stop, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, running, alpha_tick, bit_tick, done
    );

    modport slave (
`ifdef OSC_TICK_CLKOUT_EN
        output clk_out,
`endif
        input  start, stop, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, running, alpha_tick, bit_tick, done
    );

endinterface

// File: rtl/osc_tick_ctrl_mod_counter.sv
// osc_mod_counter: modulo-M counter with enable, synchronous clear and a
// terminal-count flag. The modulus may change while the count sits at 0.
module osc_mod_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_mod,
    output logic         o_tc
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;
    logic         w_tc;

    // ">=" keeps the counter from running away if the modulus ever shrinks
    // below the current count; it then simply wraps on the next enable.
    assign w_tc = (r_cnt >= (i_mod - ONE));
    assign o_tc = w_tc;

    // Count on enable, wrap at terminal count, clear overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_tc ? '0 : (r_cnt + ONE);
        end
    end

endmodule

// File: rtl/osc_tick_ctrl.sv
// osc_tick_ctrl: oscillator divider chain for the PT2262/PT2272 codec.
// Produces the alpha (oscillator period) tick and the bit-period tick,
// sequences start/stop on bit boundaries and swaps divisors only between
// bit periods. Optional square-wave output: define OSC_TICK_CLKOUT_EN.
module osc_tick_ctrl
    import osc_pkg::*;
#(
    parameter int DIV_W         = OSC_DIV_W,
    parameter int DEFAULT_DIV   = OSC_DEFAULT_DIV,
    parameter int ALPHA_PER_BIT = OSC_ALPHA_PER_BIT
) (
    input  logic  clk,
    input  logic  rst_n,
    osc_if.slave  bus
);
    localparam int               BW  = cnt_width(ALPHA_PER_BIT);
    localparam logic [BW-1:0]    APB = BW'(ALPHA_PER_BIT);
    localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);

    osc_state_t       r_state;
    osc_state_t       w_state_nxt;
    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_done;
    logic             r_cfg_err;

    logic             w_running;
    logic             w_a_tc;
    logic             w_b_tc;
    logic             w_alpha;
    logic             w_bit;
    logic             w_to_idle;
    logic             w_cnt_clr;
    logic             w_xfer;
    logic             w_div_zero;

    assign w_running  = (r_state != IDLE);
    assign w_alpha    = w_running & w_a_tc;
    assign w_bit      = w_alpha & w_b_tc;
    assign w_cnt_clr  = (w_state_nxt == IDLE);
    assign w_xfer     = bus.cfg_valid & ~r_pending;
    assign w_div_zero = (bus.cfg_div == '0);

    osc_mod_counter #(.W(DIV_W)) u_alpha_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_running),
        .i_clr (w_cnt_clr),
        .i_mod (r_div_q),
        .o_tc  (w_a_tc)
    );

    osc_mod_counter #(.W(BW)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_alpha),
        .i_clr (w_cnt_clr),
        .i_mod (APB),
        .o_tc  (w_b_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: stop always beats start, and a pending stop only
    // completes on a bit boundary so consumers never see a partial bit.
    always_comb begin
        w_state_nxt = r_state;
        w_to_idle   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.stop) w_state_nxt = RUN;
            end
            RUN: begin
                if (bus.stop) w_state_nxt = STOP_PEND;
            end
            STOP_PEND: begin
                if (w_bit) begin
                    w_state_nxt = IDLE;
                    w_to_idle   = 1'b1;
                end else if (bus.start && !bus.stop) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Divisor handshake: direct load while idle, otherwise park the value in
    // the shadow and apply it right after the next bit boundary. Leaving to
    // IDLE always happens on a bit boundary, so the shadow lands there too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q   <= DEF;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_xfer & w_div_zero;
            if (r_pending && w_bit) begin
                r_div_q   <= r_shadow;
                r_pending <= 1'b0;
            end else if (w_xfer && !w_div_zero) begin
                if (r_state == IDLE) begin
                    r_div_q <= bus.cfg_div;
                end else begin
                    r_shadow  <= bus.cfg_div;
                    r_pending <= 1'b1;
                end
            end
        end
    end

    // Completion pulse on the cycle the FSM has settled back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_to_idle;
        end
    end

    assign bus.cfg_ready  = ~r_pending;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.running    = w_running;
    assign bus.alpha_tick = w_alpha;
    assign bus.bit_tick   = w_bit;
    assign bus.done       = r_done;

`ifdef OSC_TICK_CLKOUT_EN
    logic r_clk_out;

    // Square wave of period 2N, parked low whenever the chain goes idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_out <= 1'b0;
        end else if (w_to_idle) begin
            r_clk_out <= 1'b0;
        end else if (w_alpha) begin
            r_clk_out <= ~r_clk_out;
        end
    end

    assign bus.clk_out = r_clk_out;
`endif

endmodule

// File: tb/tb_osc_tick_ctrl.sv
// tb_osc_tick_ctrl: directed stimulus with a cycle-stamped scoreboard.
// Stimulus pushes expected pulse cycles and level samples; a negedge monitor
// pops and compares whenever the DUT raises a pulse or a sample is due.
module tb_osc_tick_ctrl;

    localparam int K_ALPHA = 0;
    localparam int K_BIT   = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERR   = 3;

    localparam int L_RUNNING = 0;
    localparam int L_READY   = 1;

    typedef struct {
        int cyc;
        int kind;
    } pulse_t;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } level_t;

    logic clk;
    logic rst_n;
    int   gcyc;
    int   testsRun;
    int   testsFailed;
    int   s;

    pulse_t qPulse[$];
    level_t qLevel[$];

    osc_if #(.DIV_W(16)) bus ();

    osc_tick_ctrl #(
        .DIV_W         (16),
        .DEFAULT_DIV   (100),
        .ALPHA_PER_BIT (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    function automatic string pulseName(input int k);
        case (k)
            K_ALPHA: return "alpha_tick";
            K_BIT:   return "bit_tick";
            K_DONE:  return "done";
            default: return "cfg_err";
        endcase
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, gcyc);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic cv, input logic [15:0] cd);
        bus.start     = st;
        bus.stop      = sp;
        bus.cfg_valid = cv;
        bus.cfg_div   = cd;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitUntil(input int c);
        while (gcyc < c) step(1);
    endtask

    // One-cycle stimulus pulse, then return all requests low.
    task automatic pulseStimulus(input logic st, input logic sp, input logic cv, input logic [15:0] cd);
        applyStimulus(st, sp, cv, cd);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, cd);
    endtask

    task automatic pushPulse(input int kind, input int c);
        pulse_t p;
        p.cyc  = c;
        p.kind = kind;
        qPulse.push_back(p);
    endtask

    task automatic pushAlphaRange(input int first, input int stride, input int count);
        for (int i = 0; i < count; i++) pushPulse(K_ALPHA, first + i * stride);
    endtask

    task automatic pushLevel(input int c, input int sel, input int val, input string name);
        level_t l;
        l.cyc  = c;
        l.sel  = sel;
        l.val  = val;
        l.name = name;
        qLevel.push_back(l);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        pushLevel(gcyc, L_RUNNING, 0, "running_in_reset");
        pushLevel(gcyc, L_READY, 1, "cfg_ready_in_reset");
        step(3);
        rst_n = 1'b1;
        step(1);
    endtask

    // Pulse scoreboard and level sampler, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [3:0] seen;
        seen = {bus.cfg_err, bus.done, bus.bit_tick, bus.alpha_tick};
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = -1;
            for (int i = 0; i < qPulse.size(); i++) begin
                if (qPulse[i].kind == k) begin
                    idx = i;
                    break;
                end
            end
            if (seen[k]) begin
                if (idx < 0) begin
                    checkOutput({pulseName(k), "_unexpected"}, gcyc, -1);
                end else begin
                    checkOutput({pulseName(k), "_cycle"}, gcyc, qPulse[idx].cyc);
                    qPulse.delete(idx);
                end
            end else if (idx >= 0 && qPulse[idx].cyc <= gcyc) begin
                checkOutput({pulseName(k), "_missing"}, int'(seen[k]), 1);
                qPulse.delete(idx);
            end
        end
        for (int i = qLevel.size() - 1; i >= 0; i--) begin
            if (qLevel[i].cyc == gcyc) begin
                if (qLevel[i].sel == L_RUNNING)
                    checkOutput(qLevel[i].name, int'(bus.running), qLevel[i].val);
                else
                    checkOutput(qLevel[i].name, int'(bus.cfg_ready), qLevel[i].val);
                qLevel.delete(i);
            end
        end
    end

`ifdef OSC_TICK_CLKOUT_EN
    logic clkModel;
    initial clkModel = 1'b0;

    // Square wave must flip once per alpha tick observed, from 0 after reset.
    always @(negedge clk) begin
        if (!rst_n) clkModel = 1'b0;
        checkOutput("clk_out", int'(bus.clk_out), int'(clkModel));
        if (bus.alpha_tick) clkModel = ~clkModel;
    end
`endif

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
        step(1);
        doReset();

        // N = 4 loaded while idle, then a run stopped at cycle 50.
        pushLevel(gcyc + 1, L_READY, 1, "cfg_ready_idle_load");
        pulseStimulus(1'b0, 1'b0, 1'b1, 16'd4);
        step(2);
        s = gcyc;
        pushLevel(s, L_RUNNING, 0, "running_before_start");
        pushLevel(s + 1, L_RUNNING, 1, "running_cycle1");
        pushAlphaRange(s + 4, 4, 32);
        pushPulse(K_BIT, s + 128);
        pushPulse(K_DONE, s + 129);
        pushLevel(s + 100, L_RUNNING, 1, "running_stop_pend");
        pushLevel(s + 128, L_RUNNING, 1, "running_at_boundary");
        pushLevel(s + 129, L_RUNNING, 0, "running_after_done");
        pulseStimulus(1'b1, 1'b0, 1'b0, 16'd0);
        waitUntil(s + 50);
        pulseStimulus(1'b0, 1'b1, 1'b0, 16'd0);
        waitUntil(s + 170);

        // Divisor 2 offered at cycle 10 of a N = 4 run.
        s = gcyc;
        pushAlphaRange(s + 4, 4, 32);
        pushPulse(K_BIT, s + 128);
        pushAlphaRange(s + 130, 2, 32);
        pushPulse(K_BIT, s + 192);
        pushPulse(K_DONE, s + 193);
        pushLevel(s + 10, L_READY, 1, "cfg_ready_before_shadow");
        pushLevel(s + 11, L_READY, 0, "cfg_ready_shadow_busy");
        pushLevel(s + 128, L_READY, 0, "cfg_ready_at_boundary");
        pushLevel(s + 129, L_READY, 1, "cfg_ready_after_apply");
        pushLevel(s + 193, L_RUNNING, 0, "running_after_done2");
        pulseStimulus(1'b1, 1'b0, 1'b0, 16'd0);
        waitUntil(s + 10);
        pulseStimulus(1'b0, 1'b0, 1'b1, 16'd2);
        waitUntil(s + 140);
        pulseStimulus(1'b0, 1'b1, 1'b0, 16'd2);
        waitUntil(s + 220);

        // Zero divisor rejected; default divisor of 100 still in force.
        doReset();
        s = gcyc;
        pushPulse(K_ERR, s + 1);
        pushLevel(s + 1, L_READY, 1, "cfg_ready_after_err");
        pulseStimulus(1'b0, 1'b0, 1'b1, 16'd0);
        step(2);
        s = gcyc;
        pushPulse(K_ALPHA, s + 100);
        pushPulse(K_ALPHA, s + 200);
        pushPulse(K_ALPHA, s + 300);
        pulseStimulus(1'b1, 1'b0, 1'b0, 16'd0);
        waitUntil(s + 350);
        doReset();

        // Reset at cycle 70 of an N = 4 run with a divisor parked in shadow.
        pulseStimulus(1'b0, 1'b0, 1'b1, 16'd4);
        step(2);
        s = gcyc;
        pushAlphaRange(s + 4, 4, 17);
        pushLevel(s + 21, L_READY, 0, "cfg_ready_pending");
        pushLevel(s + 69, L_READY, 0, "cfg_ready_pending_late");
        pulseStimulus(1'b1, 1'b0, 1'b0, 16'd0);
        waitUntil(s + 20);
        pulseStimulus(1'b0, 1'b0, 1'b1, 16'd7);
        waitUntil(s + 70);
        doReset();
        pushLevel(gcyc + 2, L_RUNNING, 0, "running_after_abort");
        step(10);

        // start & stop together in IDLE; stop cancelled by start mid-bit.
        pulseStimulus(1'b0, 1'b0, 1'b1, 16'd4);
        step(2);
        pushLevel(gcyc + 1, L_RUNNING, 0, "start_stop_idle");
        pushLevel(gcyc + 2, L_RUNNING, 0, "start_stop_idle_2");
        pulseStimulus(1'b1, 1'b1, 1'b0, 16'd4);
        step(3);
        s = gcyc;
        pushAlphaRange(s + 4, 4, 64);
        pushPulse(K_BIT, s + 128);
        pushPulse(K_BIT, s + 256);
        pushPulse(K_DONE, s + 257);
        pushLevel(s + 15, L_RUNNING, 1, "running_stop_pend2");
        pushLevel(s + 257, L_RUNNING, 0, "running_after_done3");
        pulseStimulus(1'b1, 1'b0, 1'b0, 16'd4);
        waitUntil(s + 10);
        pulseStimulus(1'b0, 1'b1, 1'b0, 16'd4);
        waitUntil(s + 20);
        pulseStimulus(1'b1, 1'b0, 1'b0, 16'd4);
        waitUntil(s + 200);
        pulseStimulus(1'b0, 1'b1, 1'b0, 16'd4);
        waitUntil(s + 280);

        // N = 1, divisor offered on the bit_tick cycle itself.
        pulseStimulus(1'b0, 1'b0, 1'b1, 16'd1);
        step(2);
        s = gcyc;
        pushAlphaRange(s + 1, 1, 64);
        pushPulse(K_BIT, s + 32);
        pushPulse(K_BIT, s + 64);
        pushAlphaRange(s + 66, 2, 32);
        pushPulse(K_BIT, s + 128);
        pushPulse(K_DONE, s + 129);
        pushLevel(s + 32, L_READY, 1, "cfg_ready_on_bit");
        pushLevel(s + 33, L_READY, 0, "cfg_ready_after_bit");
        pushLevel(s + 64, L_READY, 0, "cfg_ready_next_boundary");
        pushLevel(s + 65, L_READY, 1, "cfg_ready_applied");
        pulseStimulus(1'b1, 1'b0, 1'b0, 16'd1);
        waitUntil(s + 32);
        pulseStimulus(1'b0, 1'b0, 1'b1, 16'd2);
        waitUntil(s + 70);
        pulseStimulus(1'b0, 1'b1, 1'b0, 16'd2);
        waitUntil(s + 150);

        checkOutput("pulse_queue_leftover", qPulse.size(), 0);
        checkOutput("level_queue_leftover", qLevel.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
